// File: rtl/addr_arbiter.sv
// Bus-cycle arbiter between the fetch unit (FU) and execution unit (EU); runs the T1..T4 bus sequence.
// Build option: define ADDR_ARB_ROUND_ROBIN_EN to alternate owners on contested requests (default: EU wins).
module addr_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        fu_req,
   output logic        fu_gnt,
   output logic        fu_done,
   input  logic        eu_req,
   input  logic [2:0]  eu_op,
   input  logic [1:0]  eu_seg,
   input  logic        eu_we,
   output logic        eu_gnt,
   output logic        eu_done,
   output logic [2:0]  alu_op,
   output logic [1:0]  seg_sel,
   input  logic [19:0] alu_dir,
   output logic [19:0] bus_addr,
   output logic        ale,
   output logic        rd_n,
   output logic        wr_n,
   input  logic        mem_ready,
   output logic        bus_err
);

   // state | meaning
   // IDLE  | no cycle; owner chosen when any request is seen
   // T1    | address phase, ale high
   // T2    | strobe asserted, address latched onto the bus
   // T3    | strobe held, mem_ready sampled
   // TW    | wait state, counts toward timeout
   // T4    | owner done pulse, optional bus_err
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_T3   = 3'd3;
   localparam logic [2:0] S_TW   = 3'd4;
   localparam logic [2:0] S_T4   = 3'd5;

   // The 15th wait state is the one entered with the counter at 14.
   localparam logic [3:0] WAIT_LAST = 4'd14;

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic        owner_eu;
   logic        pick_eu;
   logic [2:0]  op_q;
   logic [1:0]  seg_q;
   logic        we_q;
   logic [3:0]  wait_cnt;
   logic        err_q;
   logic [19:0] addr_q;
   logic        active;
   logic        strobe;
   logic        any_req;

   assign any_req = fu_req | eu_req;

`ifdef ADDR_ARB_ROUND_ROBIN_EN
   // Pointer records the last owner; a contested grant goes to the other unit.
   logic rr_last_eu;

   always_comb begin
      pick_eu = eu_req;
      if (eu_req && fu_req)
         pick_eu = ~rr_last_eu;
   end

   always_ff @(posedge clk) begin
      if (rst)
         rr_last_eu <= 1'b0;
      else if (state == S_T4)
         rr_last_eu <= owner_eu;
   end
`else
   assign pick_eu = eu_req;
`endif

   always_comb begin
      state_nxt = S_IDLE;
      case (state)
         S_IDLE:  state_nxt = any_req ? S_T1 : S_IDLE;
         S_T1:    state_nxt = S_T2;
         S_T2:    state_nxt = S_T3;
         S_T3:    state_nxt = mem_ready ? S_T4 : S_TW;
         S_TW:    state_nxt = (mem_ready || (wait_cnt == WAIT_LAST)) ? S_T4 : S_TW;
         S_T4:    state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         owner_eu <= 1'b0;
         op_q     <= 3'h0;
         seg_q    <= 2'b01;
         we_q     <= 1'b0;
         wait_cnt <= 4'd0;
         err_q    <= 1'b0;
         addr_q   <= 20'h00000;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && any_req) begin
            owner_eu <= pick_eu;
            op_q     <= pick_eu ? eu_op  : 3'h0;
            seg_q    <= pick_eu ? eu_seg : 2'b01;
            we_q     <= pick_eu ? eu_we  : 1'b0;
         end
         if (state == S_T1) begin
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
            addr_q   <= alu_dir;
         end
         if (state == S_TW) begin
            wait_cnt <= wait_cnt + 4'd1;
            if (!mem_ready && wait_cnt == WAIT_LAST)
               err_q <= 1'b1;
         end
      end
   end

   assign active   = (state != S_IDLE);
   assign strobe   = (state == S_T2) || (state == S_T3) || (state == S_TW);

   assign fu_gnt   = active && !owner_eu;
   assign eu_gnt   = active && owner_eu;
   assign fu_done  = (state == S_T4) && !owner_eu;
   assign eu_done  = (state == S_T4) && owner_eu;
   assign alu_op   = active ? op_q  : 3'h0;
   assign seg_sel  = active ? seg_q : 2'b01;
   assign ale      = (state == S_T1);
   assign rd_n     = ~(strobe && !we_q);
   assign wr_n     = ~(strobe && we_q);
   assign bus_err  = (state == S_T4) && err_q;
   assign bus_addr = addr_q;

endmodule

// File: doc/addr_arbiter.md
ADDR_ARBITER -- requirements
Module: addr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  synchronous, active-high reset
REQ-002 The block SHALL provide these fetch-unit (FU) ports:
- fu_req  in  1  instruction-fetch cycle request; FU holds it until fu_done
- fu_gnt  out  1  FU owns the current bus cycle
- fu_done  out  1  one-cycle pulse ending the FU cycle
REQ-003 The block SHALL provide these execution-unit (EU) ports:
- eu_req  in  1  operand cycle request; EU holds it until eu_done
- eu_op  in  3  addressing mode 1..5 for the address unit
- eu_seg  in  2  segment register select for the EU cycle
- eu_we  in  1  1 = write cycle, 0 = read cycle
- eu_gnt  out  1  EU owns the current bus cycle
- eu_done  out  1  one-cycle pulse ending the EU cycle
REQ-004 The block SHALL provide these address-unit ports:
- alu_op  out  3  mode driven to the address unit
- seg_sel  out  2  segment select driven to the address unit
- alu_dir  in  20  combinational physical address returned by the address unit
REQ-005 The block SHALL provide these memory-bus ports:
- bus_addr  out  20  registered physical address
- ale  out  1  address latch enable
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- mem_ready  in  1  memory ready; sampled in T3 and TW
- bus_err  out  1  one-cycle timeout pulse

Function
REQ-006 The block SHALL implement the states IDLE, T1, T2, T3, TW and T4, one state per clock.
REQ-007 In IDLE, when fu_req or eu_req is 1, the block SHALL select an owner and enter T1 on the next edge; with no request it SHALL stay in IDLE.
REQ-008 The block SHALL give fixed priority to EU over FU when both request in the same IDLE cycle (default build).
REQ-009 The selected owner's grant SHALL be 1 from T1 through T4 inclusive and 0 in IDLE; at most one grant SHALL be 1 at any time.
REQ-010 For an FU owner, the block SHALL drive alu_op=3'h0 and seg_sel=2'b01 (CS) from T1 to T4.
REQ-011 For an EU owner, the block SHALL drive alu_op=eu_op and seg_sel=eu_seg, both captured at the IDLE-to-T1 edge and held to T4.
REQ-012 In IDLE, the block SHALL drive alu_op=3'h0 and seg_sel=2'b01.
REQ-013 In T1, ale SHALL be 1, and bus_addr SHALL load alu_dir on the T1-to-T2 edge and hold it until the next T1-to-T2 edge.
REQ-014 In T2, T3 and TW, the block SHALL drive rd_n=0 for a read and wr_n=0 for a write; otherwise both SHALL be 1 and never 0 together.
REQ-015 In T3, the block SHALL go to T4 if mem_ready=1, else to TW.
REQ-016 In TW, the block SHALL go to T4 when mem_ready=1, else stay in TW.
REQ-017 A 4-bit wait counter SHALL clear in T1 and increment once per TW cycle.
REQ-018 If the wait counter reaches 15 with mem_ready=0, the block SHALL go to T4 and pulse bus_err for that T4.
REQ-019 In T4, the owner's done SHALL pulse for exactly one cycle, and the next state SHALL be IDLE.
REQ-020 Minimum cycle latency SHALL be 5 clocks from request sampled in IDLE to done (IDLE, T1, T2, T3, T4).
REQ-021 A request deasserted mid-cycle SHALL NOT abort the cycle.
REQ-022 A request from the other unit raised mid-cycle SHALL wait for IDLE.

Reset
REQ-023 While rst=1 at a clock edge, the next state SHALL be IDLE, with fu_gnt=eu_gnt=fu_done=eu_done=ale=bus_err=0, rd_n=wr_n=1, bus_addr=20'h00000, alu_op=3'h0, seg_sel=2'b01, wait counter=0, and round-robin pointer=FU.
REQ-024 Reset asserted mid-cycle SHALL abandon the cycle with no done pulse, and the strobes SHALL be deasserted from the following cycle.

Configuration
REQ-025 With macro ADDR_ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL alternate owners: a pointer flips to the other unit after each completed cycle, and a lone requester is always granted.
REQ-026 Without ADDR_ARB_ROUND_ROBIN_EN, the fixed EU-over-FU priority of REQ-008 SHALL apply and no pointer SHALL exist.

Verification
REQ-027 FU read: fu_req=1, alu_dir=20'h12345, mem_ready=1 -> ale in T1, bus_addr=20'h12345 from T2, rd_n=0 for 2 cycles, fu_done 5 clocks after the request.
REQ-028 EU write: eu_req=1, eu_op=3'h5, eu_seg=2'b11, eu_we=1 -> alu_op=3'h5 and seg_sel=2'b11 held T1 to T4, wr_n=0, rd_n=1 throughout.
REQ-029 Both requests each cycle -> default build: EU granted every cycle; ADDR_ARB_ROUND_ROBIN_EN build: grants EU, FU, EU, FU.
REQ-030 Wait states: mem_ready=0 for 3 cycles after T3 -> 3 TW cycles, done at clock 8.
REQ-031 Timeout: mem_ready stuck at 0 -> 15 TW cycles, then T4 with bus_err=1 and done=1 for one cycle.
REQ-032 Reset mid-TW -> IDLE on the next edge, rd_n=1, no done pulse, bus_addr=20'h00000.
